lut_layer_sequencer: RTL
========================

// Module: lut_layer_sequencer
// PURPOSE
// - Time-multiplexed evaluator for one layer of 6-input, 1-output LUT neurons.
// - Truth tables live in one shared, runtime-loadable distributed RAM instead of per-neuron ROMs.
// - Accepts one pre-gathered fan-in address vector per transaction and looks up one neuron per cycle.
// - Returns the NUM_NEURONS-bit layer output over a valid/ready stream.
// - Sits between the fan-in wiring of layer k and the input of layer k+1.
// PARAMETERS
// - NUM_NEURONS  default 64   neurons in the layer; range 2..256.
// - FANIN_BITS   default 6    LUT address width; table depth per neuron = 2**FANIN_BITS.
// - IDX_W        default 8    neuron index width; requires 2**IDX_W >= NUM_NEURONS.
// PORTS
// - clk           in   1                   sole clock, rising edge.
// - rst_n         in   1                   asynchronous, active-low reset.
// - s_valid       in   1                   input vector valid.
// - s_ready       out  1                   sequencer can accept an input vector.
// - s_addr        in   NUM_NEURONS*FANIN_BITS  LUT address for neuron i at [i*FANIN_BITS +: FANIN_BITS].
// - m_valid       out  1                   layer result valid.
// - m_ready       in   1                   downstream accepts the result.
// - m_data        out  NUM_NEURONS          bit i = output of neuron i.
// - cfg_valid     in   1                   truth-table bit write request.
// - cfg_ready     out  1                   write accepted this cycle.
// - cfg_neuron    in   IDX_W                target neuron.
// - cfg_addr      in   FANIN_BITS           truth-table row.
// - cfg_data      in   1                   row value.
// - perf_vec_cnt  out  32                  completed-transaction count (optional feature).
// BEHAVIOUR
// - Reset values: state = IDLE, s_ready = 0 during reset, m_valid = 0, m_data = 0, perf_vec_cnt = 0.
// - Reset does NOT clear table RAM; contents are undefined until loaded.
// - States:
//   - IDLE: s_ready = ~cfg_valid, cfg_ready = 1.
//     - cfg_valid has priority; a write commits at the edge: tbl[cfg_neuron][cfg_addr] <= cfg_data.
//     - s_valid & s_ready: capture s_addr, idx <= 0, go to RUN.
//   - RUN: on each edge, rd <= tbl[idx][addr_idx], pend <= idx, idx++.
//     - A previous pending rd is written to m_data[pend].
//     - After issuing idx = NUM_NEURONS-1, go to DRAIN.
//   - DRAIN: write the last rd to m_data[NUM_NEURONS-1], set m_valid <= 1, go to DONE.
//   - DONE: hold m_data and m_valid until m_ready; on m_valid & m_ready, m_valid <= 0 and go to IDLE.
//     - m_data holds its last value after the handshake.
// - Latency: accept edge T gives m_valid high after edge T+NUM_NEURONS+1; throughput is one vector per NUM_NEURONS+3 cycles minimum.
// - In any state other than IDLE: s_ready = 0 and cfg_ready = 0; cfg writes are stalled, never dropped or partially applied.
// - cfg_neuron >= NUM_NEURONS: the write is acknowledged (cfg_ready = 1) and discarded.
// - s_addr is sampled only at the accept edge; later changes have no effect.
// - Reset asserted mid-RUN or mid-DONE: immediate return to IDLE, m_valid = 0, in-flight vector lost, table intact.
// - m_ready with m_valid = 0 is ignored.
// CONFIGURATION
// - Macro LUTSEQ_PERF_CNT_EN:
//   - Defined: perf_vec_cnt increments by 1 on every m_valid & m_ready edge, saturates at 32'hFFFF_FFFF, and is cleared only by rst_n.
//   - Undefined: perf_vec_cnt is tied to 32'h0 and no counter logic is built.
// TESTING
// - T1 load, NUM_NEURONS=4: load neuron0 tbl = (a[1] & ~a[0]); neuron1 all 0; neuron2 all 1; neuron3 tbl[r] = r[5]; send s_addr={6'h20,6'h00,6'h00,6'h02} -> m_data=4'b1101, m_valid after exactly 5 edges.
// - T2 backpressure: hold m_ready=0 for 10 cycles -> m_valid and m_data stable, s_ready=0, cfg_ready=0; m_ready=1 -> IDLE next edge, s_ready=1.
// - T3 contention: cfg_valid=1 and s_valid=1 together in IDLE -> write commits, s_ready=0 that cycle; vector accepted on the next edge after cfg_valid drops.
// - T4 mid-run reset: pulse rst_n low 1 cycle after accept -> m_valid=0, m_data=0; resend the T1 vector -> 4'b1101 (table survives reset).
// - T5 rewrite between vectors: flip neuron2 to all-0, resend the T1 vector -> 4'b1001; cfg_neuron=9 write -> acknowledged, no table change.
// - T6 with LUTSEQ_PERF_CNT_EN: 3 completed transactions -> perf_vec_cnt=3; without the macro -> perf_vec_cnt=0 throughout.

Source files
------------

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer
//   Time-multiplexed evaluator for one layer of FANIN_BITS-input LUT neurons.
//   All truth tables share one runtime-loadable RAM; one neuron is looked up
//   per cycle and the full layer result is returned on a valid/ready stream.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds valid and payload until that edge, and ready
//   may depend combinationally on valid only where noted (s_ready drops while
//   cfg_valid is high, because table writes take priority in IDLE).
//
//   Optional feature: define LUTSEQ_PERF_CNT_EN to build the completed-vector
//   counter on perf_vec_cnt; otherwise perf_vec_cnt is tied to zero.
//
//   dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE).
module lut_layer_sequencer #(
  parameter int NUM_NEURONS = 64,
  parameter int FANIN_BITS  = 6,
  parameter int IDX_W       = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [NUM_NEURONS*FANIN_BITS-1:0] s_addr,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [NUM_NEURONS-1:0]            m_data,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [IDX_W-1:0]                  cfg_neuron,
  input  logic [FANIN_BITS-1:0]             cfg_addr,
  input  logic                              cfg_data,
  output logic [31:0]                       perf_vec_cnt,
  output logic [1:0]                        dbg_state
);

  localparam int DEPTH = 1 << FANIN_BITS;
  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Shared truth-table storage: one DEPTH-bit row vector per neuron.
  logic [DEPTH-1:0] r_tbl [NUM_NEURONS];

  logic                              r_live;
  logic [NUM_NEURONS*FANIN_BITS-1:0] r_addr;
  logic [NW-1:0]                     r_idx;
  logic [NW-1:0]                     r_pend;
  logic                              r_pend_vld;
  logic                              r_rd;
  logic                              r_m_valid;
  logic [NUM_NEURONS-1:0]            r_m_data;

  logic                  w_s_ready;
  logic                  w_cfg_ready;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_drain;
  logic                  w_release;
  logic                  w_last;
  logic                  w_cfg_in_range;
  logic                  w_tbl_we;
  logic [NW-1:0]         w_cfg_idx;
  logic [FANIN_BITS-1:0] w_cur_addr;
  logic                  w_rd_bit;

  assign w_last         = (r_idx == NW'(NUM_NEURONS - 1));
  assign w_cur_addr     = r_addr[int'(r_idx) * FANIN_BITS +: FANIN_BITS];
  assign w_rd_bit       = r_tbl[r_idx][w_cur_addr];
  assign w_cfg_idx      = cfg_neuron[NW-1:0];
  assign w_cfg_in_range = (32'(cfg_neuron) < NUM_NEURONS);
  // Out-of-range neurons are acknowledged but never reach the RAM.
  assign w_tbl_we       = cfg_valid & w_cfg_ready & w_cfg_in_range;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake readies.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_cfg_ready = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_drain     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_live keeps both readies low while reset is held.
        w_cfg_ready = r_live;
        w_s_ready   = r_live & ~cfg_valid;
        if (s_valid && w_s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_drain     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (r_m_valid && m_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Table write port; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_tbl_we) begin
      r_tbl[w_cfg_idx][cfg_addr] <= cfg_data;
    end
  end

  // Lookup pipeline: issue one neuron per cycle, retire the previous read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_rd       <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_addr     <= s_addr;
        r_idx      <= '0;
        r_pend_vld <= 1'b0;
      end
      if (w_issue) begin
        r_rd       <= w_rd_bit;
        r_pend     <= r_idx;
        r_idx      <= r_idx + 1'b1;
        r_pend_vld <= 1'b1;
        if (r_pend_vld) begin
          r_m_data[r_pend] <= r_rd;
        end
      end
      if (w_drain) begin
        r_m_data[r_pend] <= r_rd;
        r_pend_vld       <= 1'b0;
        r_m_valid        <= 1'b1;
      end
      if (w_release) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef LUTSEQ_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Saturating count of delivered layer results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (w_release && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_vec_cnt = r_perf_cnt;
`else
  assign perf_vec_cnt = 32'h0;
`endif

  assign s_ready   = w_s_ready;
  assign cfg_ready = w_cfg_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign dbg_state = r_state;

endmodule
